xor_descrambler_4: RTL and testbench



---
 rtl/xor_descrambler_4_if.sv | 21 ++
 rtl/xor_descrambler_4.sv | 107 ++++++++++
 tb/tb_xor_descrambler_4.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/xor_descrambler_4_if.sv
// Nibble stream bundle: scrambled input side (s_*) and descrambled output side (m_*).
// master drives the link and consumes the plaintext; slave is the descrambler.
interface xor_descrambler_4_if;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic       m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/xor_descrambler_4.sv
// Receive-side nibble descrambler: hunts for the sync nibble, reseeds a 7-bit LFSR,
// and XORs each payload nibble with a 4-step keystream into a registered output stream.
module xor_descrambler_4 #(
  parameter int unsigned FRAME_LEN = 4,
  parameter logic [3:0]  SYNC      = 4'hA,
  parameter logic [6:0]  SEED      = 7'h7F
) (
  input  logic                clk,
  input  logic                rst_n,
  xor_descrambler_4_if.slave  bus,
  output logic                locked
);

  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     state, state_nxt;
  logic [6:0] lfsr, lfsr_nxt;
  logic [7:0] count, count_nxt;
  logic [3:0] m_data, m_data_nxt;
  logic       m_valid, m_valid_nxt;
  logic       m_last, m_last_nxt;
  logic       locked_nxt;

  logic       s_ready;
  logic       accept;
  logic       last_beat;
  logic [6:0] ks_lfsr;
  logic [3:0] ks;
  logic       fb;

  // Four LFSR steps per nibble; the first feedback bit ends up in ks[3].
  always_comb begin
    ks_lfsr = lfsr;
    ks      = '0;
    fb      = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      fb      = ks_lfsr[6] ^ ks_lfsr[5];
      ks      = {ks[2:0], fb};
      ks_lfsr = {ks_lfsr[5:0], fb};
    end
  end

  assign s_ready   = (state == HUNT) || !m_valid || bus.m_ready;
  assign accept    = bus.s_valid && s_ready;
  assign last_beat = (count == LAST_IDX);

  always_comb begin
    state_nxt   = state;
    lfsr_nxt    = lfsr;
    count_nxt   = count;
    m_data_nxt  = m_data;
    m_last_nxt  = m_last;
    m_valid_nxt = m_valid && !bus.m_ready;

    case (state)
      HUNT: begin
        // Sync never reaches the output register, so a held final nibble survives it.
        if (accept && bus.s_data == SYNC) begin
          state_nxt = RUN;
          lfsr_nxt  = SEED;
          count_nxt = '0;
        end
      end
      RUN: begin
        if (accept) begin
          lfsr_nxt    = ks_lfsr;
          m_data_nxt  = bus.s_data ^ ks;
          m_valid_nxt = 1'b1;
          m_last_nxt  = last_beat;
          count_nxt   = count + 8'd1;
          if (last_beat) state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase

    locked_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= HUNT;
      lfsr    <= SEED;
      count   <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_nxt;
      lfsr    <= lfsr_nxt;
      count   <= count_nxt;
      m_data  <= m_data_nxt;
      m_valid <= m_valid_nxt;
      m_last  <= m_last_nxt;
      locked  <= locked_nxt;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_data;
  assign bus.m_last  = m_last;

endmodule

// File: tb/tb_xor_descrambler_4.sv
// Directed and randomized checks of xor_descrambler_4 with FRAME_LEN=4, SYNC=A, SEED=7F.
module tb_xor_descrambler_4;
  logic clk = 1'b0;
  logic rst_n;
  logic locked;
  int   checks = 0;
  int   errors = 0;

  xor_descrambler_4_if bus();

  xor_descrambler_4 #(.FRAME_LEN(4), .SYNC(4'hA), .SEED(7'h7F)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .locked (locked)
  );

  always #5 clk = ~clk;

  // Independent keystream model: returns {next_lfsr, keystream nibble}.
  function automatic logic [10:0] ks_model(input logic [6:0] l_in);
    logic [6:0] l;
    logic [3:0] k;
    logic       f;
    l = l_in;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      f = l[6] ^ l[5];
      k = {k[2:0], f};
      l = {l[5:0], f};
    end
    return {l, k};
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 4'h0;
    bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
    checks++; if (bus.m_data !== 4'h0) begin errors++; $display("FAIL reset_m_data got %h want 0", bus.m_data); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", bus.m_last); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] exp_d [4] = '{4'h5, 4'h7, 4'h5, 4'h9};
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'hA;
    @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_lock got %b want 1", locked); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_sync_fwd got %b want 0", bus.m_valid); end
    for (int i = 0; i < 4; i++) begin
      bus.s_data = 4'h5;
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i] || bus.m_last !== (i == 3) || locked !== (i != 3)) begin
        errors++;
        $display("FAIL basic_out%0d got v=%b d=%h l=%b lk=%b want v=1 d=%h l=%b lk=%b",
                 i, bus.m_valid, bus.m_data, bus.m_last, locked, exp_d[i], i == 3, i != 3);
      end
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", bus.m_valid); end
  endtask

  task automatic test_hunt_reseed();
    logic [3:0] exp_d [4] = '{4'h0, 4'h2, 4'h0, 4'hC};
    logic [3:0] junk  [2] = '{4'h3, 4'hF};
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.s_data = junk[i];
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL hunt_drop%0d got v=%b lk=%b want v=0 lk=0", i, bus.m_valid, locked);
      end
    end
    for (int f = 0; f < 2; f++) begin
      bus.s_data = 4'hA;
      @(negedge clk);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hunt_lock%0d got %b want 1", f, locked); end
      for (int i = 0; i < 4; i++) begin
        bus.s_data = 4'h0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i] || bus.m_last !== (i == 3)) begin
          errors++;
          $display("FAIL reseed_f%0d_n%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   f, i, bus.m_valid, bus.m_data, bus.m_last, exp_d[i], i == 3);
        end
      end
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_d [3] = '{4'h7, 4'h5, 4'h9};
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'hA;
    @(negedge clk);
    bus.s_data = 4'h5;
    @(negedge clk);
    bus.m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 4'h5 || bus.m_last !== 1'b0 || bus.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h l=%b rdy=%b want v=1 d=5 l=0 rdy=0",
                 c, bus.m_valid, bus.m_data, bus.m_last, bus.s_ready);
      end
    end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i] || bus.m_last !== (i == 2)) begin
        errors++;
        $display("FAIL bp_out%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, bus.m_valid, bus.m_data, bus.m_last, exp_d[i], i == 2);
      end
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_d [4] = '{4'h5, 4'h7, 4'h5, 4'h9};
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'hA;
    @(negedge clk);
    bus.s_data = 4'h5;
    repeat (2) @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 4'h0 || bus.m_last !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got v=%b d=%h l=%b lk=%b want all 0", bus.m_valid, bus.m_data, bus.m_last, locked);
    end
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'hA;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.s_data = 4'h5;
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i] || bus.m_last !== (i == 3)) begin
        errors++;
        $display("FAIL midrst_out%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, bus.m_valid, bus.m_data, bus.m_last, exp_d[i], i == 3);
      end
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] stream [$];
    logic [3:0] plain  [$];
    logic [6:0] l;
    logic [3:0] k;
    logic [3:0] p;
    int ptr, got, lasts, cyc;
    for (int f = 0; f < 200; f++) begin
      stream.push_back(4'hA);
      l = 7'h7F;
      for (int j = 0; j < 4; j++) begin
        p = 4'($urandom_range(0, 15));
        {l, k} = ks_model(l);
        stream.push_back(p ^ k);
        plain.push_back(p);
      end
    end
    ptr = 0; got = 0; lasts = 0; cyc = 0;
    while (got < 800 && cyc < 20000) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if (ptr < stream.size() && $urandom_range(0, 3) != 0) begin
        bus.s_valid = 1'b1;
        bus.s_data  = stream[ptr];
      end else begin
        bus.s_valid = 1'b0;
      end
      #1;
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (bus.m_data !== plain[got] || bus.m_last !== (got % 4 == 3)) begin
          errors++;
          $display("FAIL rand_out%0d got d=%h l=%b want d=%h l=%b", got, bus.m_data, bus.m_last, plain[got], got % 4 == 3);
        end
        if (bus.m_last) lasts++;
        got++;
      end
      if (bus.s_valid && bus.s_ready) ptr++;
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    checks++; if (got != 800) begin errors++; $display("FAIL rand_count got %0d want 800", got); end
    checks++; if (lasts != 200) begin errors++; $display("FAIL rand_last got %0d want 200", lasts); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hunt_reseed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
